// File: rtl/gp_pattern_pkg.sv
// Shared types and constants for the serial pattern checker.
package gp_pattern_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/gp_sat_count8.sv
// 8-bit saturating counter; a clear with a coincident increment lands on 1.
module gp_sat_count8
    import gp_pattern_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= {7'd0, inc};
        end else if (inc && (count_reg != ERR_MAX)) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/gp_pattern_checker.sv
// Serial pattern checker: acquires alignment to a repeating 2..16 bit pattern,
// confirms lock over clean periods, counts bit errors and drops lock on persistent corruption.
module gp_pattern_checker #(
    parameter logic [15:0] PATTERN_DATA   = 16'h0,
    parameter logic [4:0]  PATTERN_LEN    = 5'd16,
    parameter int          LOCK_MATCHES   = 2,
    parameter int          UNLOCK_PERIODS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       IN,
    input  logic       CLR_ERR,
    output logic       LOCKED,
    output logic       MATCH,
    output logic       BIT_ERR,
    output logic [7:0] ERR_COUNT
);

    import gp_pattern_pkg::*;

    if ((PATTERN_LEN < 5'd2) || (PATTERN_LEN > 5'd16)) begin : g_len_check
        $fatal(1, "gp_pattern_checker: PATTERN_LEN %0d outside 2..16", PATTERN_LEN);
    end
    if ((LOCK_MATCHES < 1) || (UNLOCK_PERIODS < 1)) begin : g_cnt_check
        $fatal(1, "gp_pattern_checker: LOCK_MATCHES and UNLOCK_PERIODS must be >= 1");
    end

    localparam logic [3:0]  PH_TOP     = 4'(PATTERN_LEN - 5'd1);
    localparam logic [16:0] LEN_MASK   = (17'd1 << PATTERN_LEN) - 17'd1;
    localparam logic [15:0] LOCK_CNT   = 16'(LOCK_MATCHES);
    localparam logic [15:0] UNLOCK_CNT = 16'(UNLOCK_PERIODS);

    state_t              state_reg, state_next;
    // The oldest history bit can never reach a window, so only MAX_LEN-1 bits are kept.
    logic [MAX_LEN-2:0]  sh_reg, sh_next;
    logic [3:0]          fill_reg, fill_next;
    logic [3:0]          phase_reg, phase_next;
    logic [15:0]         good_reg, good_next;
    logic [15:0]         bad_reg, bad_next;
    logic                period_err_reg, period_err_next;
    logic                locked_reg, match_reg, bit_err_reg;
    logic                match_next, bit_err_next, acquire;

    logic [MAX_LEN-1:0]  window;
    logic [MAX_LEN-1:0]  win_diff;
    logic                win_hit, bit_ok, at_end;
    logic [3:0]          phase_wrap;

    assign window = {sh_reg, IN};

    genvar gi;
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_win_cmp
        assign win_diff[gi] = LEN_MASK[gi] & (window[gi] ^ PATTERN_DATA[gi]);
    end

    assign win_hit    = (fill_reg == PH_TOP) && (win_diff == '0);
    assign bit_ok     = (IN == PATTERN_DATA[phase_reg]);
    assign at_end     = (phase_reg == 4'd0);
    assign phase_wrap = at_end ? PH_TOP : (phase_reg - 4'd1);

    always_comb begin
        state_next      = state_reg;
        sh_next         = sh_reg;
        fill_next       = fill_reg;
        phase_next      = phase_reg;
        good_next       = good_reg;
        bad_next        = bad_reg;
        period_err_next = period_err_reg;
        match_next      = 1'b0;
        bit_err_next    = 1'b0;
        acquire         = 1'b0;

        if (EN) begin
            sh_next = {sh_reg[MAX_LEN-3:0], IN};
            if (fill_reg != PH_TOP) begin
                fill_next = fill_reg + 4'd1;
            end

            case (state_reg)
                gp_pattern_pkg::SEARCH: begin
                    acquire = win_hit;
                end
                gp_pattern_pkg::VERIFY: begin
                    phase_next = phase_wrap;
                    if (!bit_ok) begin
                        // The offending bit may itself complete a fresh window.
                        state_next = gp_pattern_pkg::SEARCH;
                        acquire    = win_hit;
                    end else if (at_end) begin
                        match_next = 1'b1;
                        good_next  = good_reg + 16'd1;
                        if ((good_reg + 16'd1) >= LOCK_CNT) begin
                            state_next      = gp_pattern_pkg::LOCKED;
                            bad_next        = '0;
                            period_err_next = 1'b0;
                        end
                    end
                end
                gp_pattern_pkg::LOCKED: begin
                    phase_next   = phase_wrap;
                    bit_err_next = !bit_ok;
                    if (at_end) begin
                        period_err_next = 1'b0;
                        if (bit_ok && !period_err_reg) begin
                            match_next = 1'b1;
                            bad_next   = '0;
                        end else begin
                            bad_next = bad_reg + 16'd1;
                            if ((bad_reg + 16'd1) >= UNLOCK_CNT) begin
                                state_next = gp_pattern_pkg::SEARCH;
                            end
                        end
                    end else if (!bit_ok) begin
                        period_err_next = 1'b1;
                    end
                end
                default: begin
                    state_next = gp_pattern_pkg::SEARCH;
                end
            endcase

            if (acquire) begin
                match_next      = 1'b1;
                good_next       = 16'd1;
                bad_next        = '0;
                period_err_next = 1'b0;
                phase_next      = PH_TOP;
                state_next      = (LOCK_CNT == 16'd1) ? gp_pattern_pkg::LOCKED
                                                      : gp_pattern_pkg::VERIFY;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= gp_pattern_pkg::SEARCH;
            sh_reg         <= '0;
            fill_reg       <= '0;
            phase_reg      <= '0;
            good_reg       <= '0;
            bad_reg        <= '0;
            period_err_reg <= 1'b0;
            locked_reg     <= 1'b0;
            match_reg      <= 1'b0;
            bit_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sh_reg         <= sh_next;
            fill_reg       <= fill_next;
            phase_reg      <= phase_next;
            good_reg       <= good_next;
            bad_reg        <= bad_next;
            period_err_reg <= period_err_next;
            locked_reg     <= (state_next == gp_pattern_pkg::LOCKED);
            match_reg      <= match_next;
            bit_err_reg    <= bit_err_next;
        end
    end

    gp_sat_count8 u_err_count (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (CLR_ERR),
        .inc   (bit_err_next),
        .count (ERR_COUNT)
    );

    assign LOCKED  = locked_reg;
    assign MATCH   = match_reg;
    assign BIT_ERR = bit_err_reg;

endmodule

// File: doc/gp_pattern_checker.md
# gp_pattern_checker

Serial pattern checker: the receive-side counterpart of the GreenPAK pattern generator cell. Samples a one-bit stream, acquires alignment to a programmed repeating pattern of 2–16 bits, confirms lock over consecutive error-free periods, then counts bit errors and drops lock after persistent corruption. It sits beside the behavioural cell library and is used as a loopback checker for pattern-generator outputs and as a synthesizable pattern-detect block.

## Interface
- PATTERN_DATA, 16'h0: pattern bits. Only [PATTERN_LEN-1:0] are used.
- PATTERN_LEN, 5'd16: period in bits, legal range 2..16. Out-of-range values make simulation print an error and `$finish`.
- LOCK_MATCHES, 2: consecutive error-free periods required for lock (≥1). The acquiring match counts as the first.
- UNLOCK_PERIODS, 4: consecutive errored periods while locked that force a return to search (≥1).
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high; has priority over every other input.
- EN  in  1  bit-sample enable. When low, all state holds and pulse outputs are 0.
- IN  in  1  serial data, sampled when EN=1.
- CLR_ERR  in  1  clears ERR_COUNT (sampled when EN=1 or EN=0).
- LOCKED  out  1  level; high in LOCKED state.
- MATCH  out  1  one-cycle pulse per error-free completed period in any state.
- BIT_ERR  out  1  one-cycle pulse per mismatched bit while LOCKED.
- ERR_COUNT  out  8  saturating bit-error count, LOCKED state only.

## Operation
- Bit order is MSB-first per period: P[LEN-1], P[LEN-2] … P[0], repeat.
- Shift history sh[15:0] <= {sh[14:0], IN} on every enabled bit. Window w = {sh[LEN-2:0], IN}. Fill counter saturates at LEN-1.
- States:
  - SEARCH: enabled bit with fill ≥ LEN-1 and w == P[LEN-1:0] → MATCH pulse, good=1, phase=LEN-1. Go to LOCKED if LOCK_MATCHES==1, else to VERIFY.
  - VERIFY: expected bit = P[phase]; phase decrements, wrapping 0→LEN-1.
    - Mismatch → SEARCH. The same bit is also evaluated for a SEARCH match using w.
    - Bit at phase 0 matching → MATCH, good++; when good==LOCK_MATCHES → LOCKED.
  - LOCKED: same phase tracking.
    - Mismatch → BIT_ERR pulse, ERR_COUNT+1 (saturates at 255), period_err=1.
    - At phase 0, end of period: if no error in the period → MATCH, bad=0; otherwise bad++.
    - When bad reaches UNLOCK_PERIODS → SEARCH. Shift history and fill are retained.
- CLR_ERR together with a bit error in the same cycle → ERR_COUNT=1. CLR_ERR alone → 0.
- RST: state=SEARCH, sh=0, fill=0, phase=0, good=0, bad=0. Outputs LOCKED=0, MATCH=0, BIT_ERR=0, ERR_COUNT=0.
- RST asserted mid-lock discards alignment. Acquisition restarts needing LEN fresh bits.

## Timing
- All outputs are registered.
- MATCH/BIT_ERR assert in the cycle after the CLK edge that sampled the relevant bit; high for exactly one cycle.
- Acquisition latency, best case: LOCKED rises one cycle after the edge sampling bit LEN·LOCK_MATCHES of an aligned stream.
- Unlock: LOCKED falls one cycle after the edge sampling the final bit (phase 0) of the UNLOCK_PERIODS-th consecutive errored period.
- EN low cycles are invisible: latencies count enabled bits only.

## Structure
- Shared package gp_pattern_pkg holds:
  - state enum {SEARCH, VERIFY, LOCKED} (2 bits);
  - MAX_LEN=16;
  - ERR_MAX=8'hFF.
- One sub-module, gp_sat_count8: 8-bit saturating counter with sync clear, increment, clear-then-increment priority. Used for ERR_COUNT.
- Phase, good and bad counters stay inline in the top module.

## Test plan
All scenarios use PATTERN_LEN=8, PATTERN_DATA=8'hB4, defaults otherwise.
- Reset: RST high 2 cycles with random IN → LOCKED=0, MATCH=0, BIT_ERR=0, ERR_COUNT=0. No MATCH until ≥8 enabled bits.
- Acquire: aligned repeating B4 stream → MATCH one cycle after bit 8. MATCH plus LOCKED=1 one cycle after bit 16.
- Single error: locked, invert one bit → one BIT_ERR pulse, ERR_COUNT=1, LOCKED stays 1. Next clean period gives MATCH.
- Unlock: one flipped bit in each of 4 consecutive periods → LOCKED=0 after the 4th period end, ERR_COUNT=4.
- Verify abort: one bit flipped in the second period before lock → returns to SEARCH, LOCKED never rises. Clean stream then reacquires with MATCH ≤8 bits later.
- Saturation/enable:
  - 300 errors → ERR_COUNT=255.
  - CLR_ERR coincident with an error → ERR_COUNT=1.
  - EN low for 5 cycles mid-period → no state change, lock held.
